// File: rtl/stb_pkg.sv
// rtl/stb_pkg.sv - shared store-buffer types: drain FSM states, widths, entry struct
package stb_pkg;

    typedef enum logic {
        DR_IDLE = 1'b0,
        DR_REQ  = 1'b1
    } drain_state_t;

    localparam int STB_ADDR_W = 32;
    localparam int STB_DATA_W = 32;
    localparam int STB_SEL_W  = STB_DATA_W / 8;

    // One store-buffer entry; also used by the store buffer datapath.
    typedef struct packed {
        logic [STB_ADDR_W-1:0] addr;
        logic [STB_DATA_W-1:0] data;
        logic [STB_SEL_W-1:0]  sel;
    } stb_entry_t;

endpackage

// File: rtl/stb_dcache_drain.sv
// rtl/stb_dcache_drain.sv - drains committed stores from the store buffer head into the data cache
//
// Pops the head of the store buffer into a holding register and presents it to
// the data cache until acknowledged. LSU loads take priority for new pops
// unless a fence (drain-all) is pending.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   stb_empty, stb_head_*           store buffer head entry (valid when !stb_empty)
//   stb_rd_en                       pop head entry (combinational)
//   lsummu2dcache_load_req          LSU load wants the cache port
//   dcache2stb_ack                  cache accepted the current write
//   stb2dcache_req/w_en/addr/wdata/sel  registered cache write request
//   lsummu2stb_fence                level fence request
//   stb2lsummu_fence_stall/done     fence pending / one-cycle completion pulse
//   drain_count                     wrapping count of completed writes
//
// ADDR_W/DATA_W must match the widths fixed in stb_pkg, since the holding
// register is an stb_entry_t.
module stb_dcache_drain
    import stb_pkg::*;
#(
    parameter int ADDR_W = STB_ADDR_W,
    parameter int DATA_W = STB_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stb_empty,
    input  logic [ADDR_W-1:0]   stb_head_addr,
    input  logic [DATA_W-1:0]   stb_head_data,
    input  logic [DATA_W/8-1:0] stb_head_sel,
    output logic                stb_rd_en,
    input  logic                lsummu2dcache_load_req,
    input  logic                dcache2stb_ack,
    output logic                stb2dcache_req,
    output logic                stb2dcache_w_en,
    output logic [ADDR_W-1:0]   stb2dcache_addr,
    output logic [DATA_W-1:0]   stb2dcache_wdata,
    output logic [DATA_W/8-1:0] stb2dcache_sel,
    input  logic                lsummu2stb_fence,
    output logic                stb2lsummu_fence_stall,
    output logic                stb2lsummu_fence_done,
    output logic [15:0]         drain_count
);

    drain_state_t state_q, state_d;
    stb_entry_t   hold_q, hold_d;
    logic [15:0]  count_q, count_d;
    logic         done_seen_q, done_seen_d;

    logic pop_ok;
    logic drained;

    // A pending fence overrides load priority so the drain cannot starve.
    assign pop_ok  = !stb_empty && (!lsummu2dcache_load_req || lsummu2stb_fence);
    assign drained = (state_q == DR_IDLE) && stb_empty;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_d   = count_q;
        stb_rd_en = 1'b0;

        case (state_q)
            DR_IDLE: begin
                if (pop_ok) begin
                    stb_rd_en = 1'b1;
                    hold_d    = '{addr: stb_head_addr, data: stb_head_data, sel: stb_head_sel};
                    state_d   = DR_REQ;
                end
            end
            DR_REQ: begin
                // The request is held until ack; a load never aborts it.
                if (dcache2stb_ack) begin
                    count_d = count_q + 16'd1;
                    if (pop_ok) begin
                        stb_rd_en = 1'b1;
                        hold_d    = '{addr: stb_head_addr, data: stb_head_data, sel: stb_head_sel};
                    end else begin
                        state_d = DR_IDLE;
                    end
                end
            end
            default: state_d = DR_IDLE;
        endcase
    end

    // done fires on the first drained cycle of a fence and stays quiet until
    // the fence request drops.
    assign stb2lsummu_fence_stall = lsummu2stb_fence && !drained;
    assign stb2lsummu_fence_done  = lsummu2stb_fence && drained && !done_seen_q;
    assign done_seen_d            = lsummu2stb_fence && (done_seen_q || drained);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DR_IDLE;
            hold_q      <= '0;
            count_q     <= '0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            count_q     <= count_d;
            done_seen_q <= done_seen_d;
        end
    end

    assign stb2dcache_req   = (state_q == DR_REQ);
    assign stb2dcache_w_en  = stb2dcache_req;
    assign stb2dcache_addr  = hold_q.addr;
    assign stb2dcache_wdata = hold_q.data;
    assign stb2dcache_sel   = hold_q.sel;
    assign drain_count      = count_q;

endmodule
